// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the expression evaluator and recogniser.
package expr_pkg;

  typedef enum logic [1:0] {S_OPND, S_OPER, S_ERR} state_e;

  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  localparam int unsigned W_DEF = 16;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier shared by the recogniser and evaluator.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] i_ch,
  output logic       o_is_digit,
  output logic       o_is_plus,
  output logic       o_is_mul,
  output logic       o_is_eq,
  output logic       o_is_bad,
  output logic [3:0] o_digit
);

  logic [7:0] w_off;

  always_comb begin
    w_off      = i_ch - CH_0;
    o_is_digit = (i_ch >= CH_0) && (i_ch <= CH_9);
    o_is_plus  = (i_ch == CH_PLUS);
    o_is_mul   = (i_ch == CH_MUL);
    o_is_eq    = (i_ch == CH_EQ);
    o_is_bad   = !(o_is_digit || o_is_plus || o_is_mul || o_is_eq);
    o_digit    = w_off[3:0];
  end

endmodule

// File: rtl/expr_eval.sv
// Evaluates a '+'/'*' digit expression terminated by '='; '*' binds tighter than '+'.
// EXPR_EVAL_MULTIDIGIT_EN lets consecutive digits form one multi-digit number.
module expr_eval
  import expr_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic [W-1:0] result,
  output logic         res_valid,
  output logic         done,
  output logic         err
);

  logic w_is_digit, w_is_plus, w_is_mul, w_is_eq, w_is_bad;
  logic [3:0] w_digit;

  expr_char_class u_class (
    .i_ch       (in),
    .o_is_digit (w_is_digit),
    .o_is_plus  (w_is_plus),
    .o_is_mul   (w_is_mul),
    .o_is_eq    (w_is_eq),
    .o_is_bad   (w_is_bad),
    .o_digit    (w_digit)
  );

  state_e r_state, r_state_d;
  logic [W-1:0] r_sum, r_sum_d, r_term, r_term_d, r_result, r_result_d;
  logic r_mul, r_mul_d, r_res_valid, r_res_valid_d, r_done, r_done_d, r_err, r_err_d;

  logic [W-1:0] w_dig_w, w_new_term;

`ifdef EXPR_EVAL_MULTIDIGIT_EN
  logic [W-1:0] r_num, r_num_d, r_base, r_base_d;
  logic [W-1:0] w_base_new, w_num_ext, w_term_ext;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_OPND;
      r_sum       <= '0;
      r_term      <= '0;
      r_result    <= '0;
      r_mul       <= 1'b0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef EXPR_EVAL_MULTIDIGIT_EN
      r_num       <= '0;
      r_base      <= '0;
`endif
    end else begin
      r_state     <= r_state_d;
      r_sum       <= r_sum_d;
      r_term      <= r_term_d;
      r_result    <= r_result_d;
      r_mul       <= r_mul_d;
      r_res_valid <= r_res_valid_d;
      r_done      <= r_done_d;
      r_err       <= r_err_d;
`ifdef EXPR_EVAL_MULTIDIGIT_EN
      r_num       <= r_num_d;
      r_base      <= r_base_d;
`endif
    end
  end

  always_comb begin
    w_dig_w = W'(w_digit);
`ifdef EXPR_EVAL_MULTIDIGIT_EN
    // base is the pending product the new number will multiply into
    w_base_new = r_mul ? r_term : W'(1);
    w_new_term = W'(w_base_new * w_dig_w);
    w_num_ext  = W'(r_num * W'(10)) + w_dig_w;
    w_term_ext = W'(r_base * w_num_ext);
`else
    w_new_term = r_mul ? W'(r_term * w_dig_w) : w_dig_w;
`endif
  end

  always_comb begin
    r_state_d     = r_state;
    r_sum_d       = r_sum;
    r_term_d      = r_term;
    r_result_d    = r_result;
    r_mul_d       = r_mul;
    r_res_valid_d = r_res_valid;
    r_done_d      = 1'b0;
    r_err_d       = r_err;
`ifdef EXPR_EVAL_MULTIDIGIT_EN
    r_num_d       = r_num;
    r_base_d      = r_base;
`endif
    if (in_valid) begin
      case (r_state)
        S_OPND: begin
          if (w_is_digit) begin
            r_term_d      = w_new_term;
            r_mul_d       = 1'b0;
            r_result_d    = r_sum + w_new_term;
            r_res_valid_d = 1'b1;
            r_state_d     = S_OPER;
`ifdef EXPR_EVAL_MULTIDIGIT_EN
            r_num_d       = w_dig_w;
            r_base_d      = w_base_new;
`endif
          end else begin
            r_state_d     = S_ERR;
            r_err_d       = 1'b1;
            r_res_valid_d = 1'b0;
          end
        end
        S_OPER: begin
          if (w_is_bad) begin
            r_state_d     = S_ERR;
            r_err_d       = 1'b1;
            r_res_valid_d = 1'b0;
          end else if (w_is_plus) begin
            r_sum_d       = r_sum + r_term;
            r_term_d      = '0;
            r_res_valid_d = 1'b0;
            r_state_d     = S_OPND;
          end else if (w_is_mul) begin
            r_mul_d       = 1'b1;
            r_res_valid_d = 1'b0;
            r_state_d     = S_OPND;
          end else if (w_is_eq) begin
            r_result_d    = r_sum + r_term;
            r_done_d      = 1'b1;
            r_sum_d       = '0;
            r_term_d      = '0;
            r_mul_d       = 1'b0;
            r_res_valid_d = 1'b0;
            r_state_d     = S_OPND;
          end else begin
`ifdef EXPR_EVAL_MULTIDIGIT_EN
            r_num_d       = w_num_ext;
            r_term_d      = w_term_ext;
            r_result_d    = r_sum + w_term_ext;
`else
            r_state_d     = S_ERR;
            r_err_d       = 1'b1;
            r_res_valid_d = 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign res_valid = r_res_valid;
  assign done      = r_done;
  assign err       = r_err;

endmodule
